// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} hex patterns and blank code.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Indexed by nibble value; the first entry listed is F, the last is 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Registered nibble-to-segment decoder with a blank override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segments
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            segments <= SEG_BLANK;
        end else begin
            segments <= blank ? SEG_BLANK : hex_to_seg(nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver; new values latch into the shown value
// only at frame boundaries so a frame never mixes old and new digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
    output logic                  ready,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            segments
);

    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned DATA_W = 4 * DIGITS;

    logic [CNT_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] pending;

    logic       tick_c;
    logic       frame_c;
    logic [3:0] nibble_c;
    logic       blank_c;
    logic       all_zero_c;

    assign tick_c  = (div_cnt == CNT_W'(DIV - 1));
    assign frame_c = tick_c && (idx == IDX_W'(DIGITS - 1));

    // ready doubles as the inverse of the pending-valid flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            idx      <= '0;
            shadow   <= '0;
            pending  <= '0;
            ready    <= 1'b1;
            digit_en <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + CNT_W'(1);
            if (tick_c) begin
                idx <= frame_c ? '0 : idx + IDX_W'(1);
            end
            if (frame_c && !ready) begin
                shadow <= pending;
                ready  <= 1'b1;
            end
            if (load && ready) begin
                pending <= data;
                ready   <= 1'b0;
            end
            digit_en <= DIGITS'(1) << idx;
        end
    end

    // Walk from the top digit down so all_zero_c means "this and every higher nibble is 0".
    always_comb begin
        nibble_c   = '0;
        blank_c    = 1'b0;
        all_zero_c = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero_c = all_zero_c && (shadow[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nibble_c = shadow[4*i +: 4];
                blank_c  = blank_lz && (i != 0) && all_zero_c;
            end
        end
    end

    seg7_decode u_decode (
        .clock    (clock),
        .reset_n  (reset_n),
        .nibble   (nibble_c),
        .blank    (blank_c),
        .segments (segments)
    );

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIGITS=4, DIV=4 against a cycle-count based display model.
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned FRAME  = DIGITS * DIV;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] data;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  digit_en;
    logic [6:0]  segments;

    int checks = 0;
    int errors = 0;

    int unsigned m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    bit          m_pv;
    logic [3:0]  e_en;
    logic [6:0]  e_seg;

    always #5 clock = ~clock;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .data     (data),
        .blank_lz (blank_lz),
        .ready    (ready),
        .digit_en (digit_en),
        .segments (segments)
    );

    function automatic logic [6:0] seg_of(input int unsigned v);
        case (v)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input logic [15:0] val, input int unsigned pos, input bit blz);
        int unsigned v;
        v = int'(val);
        if (blz && pos >= 1 && (v >> (4 * pos)) == 0) return 7'h7F;
        return seg_of((v >> (4 * pos)) % 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp_v);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare shortly after.
    task automatic step(input bit rst_n_i, input bit ld, input logic [15:0] d, input bit blz);
        int unsigned slot;
        bit boundary;
        bit pv_old;
        reset_n  = rst_n_i;
        load     = ld;
        data     = d;
        blank_lz = blz;
        @(posedge clock);
        if (!rst_n_i) begin
            m_t       = 0;
            m_shadow  = 16'h0;
            m_pending = 16'h0;
            m_pv      = 1'b0;
            e_en      = 4'h0;
            e_seg     = 7'h7F;
        end else begin
            slot     = (m_t / DIV) % DIGITS;
            e_en     = 4'(1 << slot);
            e_seg    = expect_seg(m_shadow, slot, blz);
            boundary = (m_t % FRAME) == FRAME - 1;
            pv_old   = m_pv;
            if (boundary && m_pv) begin
                m_shadow = m_pending;
                m_pv     = 1'b0;
            end
            if (ld && !pv_old) begin
                m_pending = d;
                m_pv      = 1'b1;
            end
            m_t++;
        end
        #1;
        check("digit_en", 32'(digit_en), 32'(e_en));
        check("segments", 32'(segments), 32'(e_seg));
        check("ready",    32'(ready),    32'(!m_pv));
    endtask

    task automatic idle(input int n, input bit blz);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, blz);
    endtask

    task automatic wait_ready(input bit blz);
        for (int i = 0; i < 2 * FRAME && m_pv; i++) step(1'b1, 1'b0, 16'h0, blz);
        check("ready_timeout", 32'(m_pv), 32'(0));
    endtask

    // Step until the next edge is a frame-boundary edge.
    task automatic align_boundary(input bit blz);
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != FRAME - 1; i++) step(1'b1, 1'b0, 16'h0, blz);
        check("align_timeout", 32'(m_t % FRAME), 32'(FRAME - 1));
    endtask

    initial begin
        bit blz;
        m_t = 0; m_shadow = 0; m_pending = 0; m_pv = 0;
        reset_n = 1'b0; load = 1'b0; data = 16'h0; blank_lz = 1'b0;

        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        step(1'b1, 1'b1, 16'h12AF, 1'b0);
        idle(3 * FRAME, 1'b0);

        step(1'b1, 1'b1, 16'h5555, 1'b0);
        step(1'b1, 1'b1, 16'h6666, 1'b0);
        idle(3 * FRAME, 1'b0);

        wait_ready(1'b1);
        step(1'b1, 1'b1, 16'h0070, 1'b1);
        idle(3 * FRAME, 1'b1);
        wait_ready(1'b1);
        step(1'b1, 1'b1, 16'h0000, 1'b1);
        idle(3 * FRAME, 1'b1);

        wait_ready(1'b0);
        align_boundary(1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b0);
        idle(3 * FRAME, 1'b0);

        blz = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) blz = ~blz;
            if ($urandom_range(0, 3) == 0)
                step(1'b1, $urandom_range(0, 5) == 0, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom), blz);
            else
                step(1'b1, 1'b0, 16'h0, blz);
        end

        wait_ready(1'b0);
        align_boundary(1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'hABCD, 1'b0);
        idle(5, 1'b0);
        check("pending_before_reset", 32'(ready), 32'(0));
        step(1'b0, 1'b0, 16'h0, 1'b0);
        idle(3 * FRAME, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
